bcd_display_scheduler: RTL and testbench
========================================

Name: bcd_display_scheduler

Overview:
Time-shares one sequential shift-add-3 (double-dabble) binary-to-BCD engine between two requesters: the 12-bit memory address channel and the 32-bit data channel that feed the seven-segment display digits. Sits between the CPU I/O path and the 7-segment decoders. Replaces per-channel combinational loops with one engine that converts one bit per cycle. Converted digits are registered and held for the decoders.

Parameters:
ADDR_W, 12, address channel width in bits
DATA_W, 32, data channel width in bits
DIGITS, 4, BCD digits produced per channel; the result is value mod 10^DIGITS

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
addr_req  in  1  level request to convert addr_in
addr_in  in  ADDR_W  address value, sampled on the grant cycle
data_req  in  1  level request to convert data_in
data_in  in  DATA_W  data value, sampled on the grant cycle
output_enable  in  1  sampled on data grant; 0 selects a blank/status code instead of conversion
input_enable  in  1  sampled on data grant; selects which status code is used
addr_ack  out  1  one-cycle pulse on the cycle the address request is granted
data_ack  out  1  one-cycle pulse on the cycle the data request is granted
busy  out  1  high while the engine is not IDLE
addr_digits  out  4*DIGITS  address BCD result, most-significant digit in the top nibble
data_digits  out  4*DIGITS  data BCD result or status code, most-significant digit in the top nibble
addr_valid  out  1  one-cycle pulse when addr_digits updates
data_valid  out  1  one-cycle pulse when data_digits updates

Behaviour:
- Reset (clock edge with reset=1):
  - State goes to IDLE; the shift register and bit counter clear.
  - addr_digits and data_digits go to 0; every ack, valid and busy output goes to 0.
  - The round-robin pointer goes to "address first".
  - Reset mid-conversion abandons the conversion; no valid pulse is emitted.
- States and transitions:
  - IDLE: when a request is pending, grant it.
    - Grant pulses the matching ack, latches the operand into the shift source, loads the bit count (ADDR_W or DATA_W), clears the BCD accumulator, then goes to SHIFT.
  - SHIFT: once per cycle:
    - Add 3 to every accumulator nibble that is greater than 4.
    - Then shift the whole {accumulator, source} left by one bit, taking the source MSB into the accumulator LSB.
    - Decrement the count; when it reaches 0, go to DONE.
    - The nibble shifted out of the top digit is discarded.
  - DONE: write the accumulator to the granted channel's digit register, pulse its valid, return to IDLE.
- Status bypass: if data is granted with output_enable=0, there is no SHIFT.
  - The next cycle is DONE, and every data nibble becomes 4'b1011 if input_enable=1, else 4'b1010.
- Latency, measured from the ack cycle to the valid cycle:
  - ADDR_W+1 cycles for the address channel (13 by default).
  - DATA_W+1 cycles for the data channel (33 by default).
  - 1 cycle for the status bypass.
  - Results are visible on the outputs in the same cycle as valid.
- Arbitration:
  - A grant is possible only in IDLE.
  - If only one request is pending, that one is granted.
  - If both are pending, the channel named by the pointer is granted, and the pointer then flips to the other channel.
  - A request that stays high re-converts after each completion, so a held request re-triggers continuously; holding both requests alternates strictly A, D, A, D.
- Requests, inputs and held outputs:
  - Requests are levels and are not captured while busy; the requester drops its request after seeing ack or keeps it up to request repeated refreshes.
  - addr_in, data_in, output_enable and input_enable matter only on the ack cycle; changes during SHIFT have no effect.
  - A channel's digits hold their last value while the other channel converts.
- Boundary cases:
  - All-ones data (4294967295) gives data_digits = 7295 when DIGITS=4.
  - Address 4095 gives 4095; 0 gives 0000.
- Width rules:
  - The accumulator is 4*DIGITS bits.
  - The source register is max(ADDR_W, DATA_W) bits; an address operand is left-aligned by loading it into the top ADDR_W bits.
  - The bit counter is clog2(max width + 1) bits.

Decomposition:
- Shared package bcd_pkg holds:
  - State enum {IDLE, SHIFT, DONE}.
  - Constants BCD_BLANK_IN = 4'b1011 and BCD_BLANK_OUT = 4'b1010.
  - Channel id enum {CH_ADDR, CH_DATA}.
- One sub-module, bcd_add3_stage: the combinational add-3 correction over the DIGITS nibbles, instantiated once inside the SHIFT path.
- Arbitration, the FSM and the output registers stay in the top module.

Test Plan:
- Reset then addr_req=1 with addr_in=12'd4095 -> addr_ack at cycle 1, addr_valid 13 cycles later, addr_digits=16'h4095; data_digits stays 0.
- data_req with data_in=32'd1234, output_enable=1 -> data_valid 33 cycles after data_ack, data_digits=16'h1234; data_in=32'hFFFFFFFF -> 16'h7295.
- data_req with output_enable=0, input_enable=1 -> data_valid one cycle after data_ack, data_digits=16'hBBBB; with input_enable=0 -> 16'hAAAA.
- addr_req and data_req raised in the same cycle and held -> grants alternate A, D, A, D starting with A; each result is correct for the values sampled at its ack.
- Change addr_in from 12 to 999 during SHIFT -> the result still reflects 12 (16'h0012).
- Assert reset at the 5th SHIFT cycle of a data conversion -> no data_valid; busy=0 next cycle; all digits read 0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD display scheduler.
//   state_t  : engine states (IDLE, SHIFT, DONE)
//   ch_t     : channel currently owning the engine (CH_ADDR, CH_DATA)
//   BCD_BLANK_IN / BCD_BLANK_OUT : status nibbles shown on the data digits
//                                  when the data channel is not displaying
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    CH_ADDR = 1'b0,
    CH_DATA = 1'b1
  } ch_t;

  localparam logic [3:0] BCD_BLANK_IN  = 4'b1011;
  localparam logic [3:0] BCD_BLANK_OUT = 4'b1010;

endpackage

// File: rtl/bcd_add3_stage.sv
// Combinational double-dabble correction: every nibble greater than 4 gets
// 3 added so that the following left shift carries correctly into the next
// decimal digit.
//   acc       in  4*DIGITS  BCD accumulator before correction
//   corrected out 4*DIGITS  accumulator after the add-3 step
module bcd_add3_stage #(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] acc,
  output logic [4*DIGITS-1:0] corrected
);

  always_comb begin
    corrected = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] > 4'd4)
        corrected[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

endmodule

// File: rtl/bcd_display_scheduler.sv
// Shares one bit-serial binary-to-BCD engine between the address and data
// display channels. Results are registered and held for the 7-seg decoders.
//   clock, reset              : clock, synchronous active-high reset
//   addr_req/addr_in          : address conversion request and operand
//   data_req/data_in          : data conversion request and operand
//   output_enable             : 0 on a data grant shows a status code instead
//   input_enable              : selects the status code (1 -> B, 0 -> A)
//   addr_ack/data_ack         : one-cycle grant pulses
//   busy                      : engine not idle
//   addr_digits/data_digits   : held BCD results, MS digit in the top nibble
//   addr_valid/data_valid     : one-cycle update pulses
module bcd_display_scheduler
  import bcd_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DIGITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                addr_req,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic                data_req,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                output_enable,
  input  logic                input_enable,
  output logic                addr_ack,
  output logic                data_ack,
  output logic                busy,
  output logic [4*DIGITS-1:0] addr_digits,
  output logic [4*DIGITS-1:0] data_digits,
  output logic                addr_valid,
  output logic                data_valid
);

  localparam int SRC_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(SRC_W + 1);
  localparam int ACC_W = 4 * DIGITS;

  state_t             state, state_nxt;
  ch_t                ch;
  logic               rr_addr_first;
  logic [SRC_W-1:0]   src;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_corr;
  logic               grant_addr, grant_data;

  bcd_add3_stage #(.DIGITS(DIGITS)) u_add3 (
    .acc       (acc),
    .corrected (acc_corr)
  );

  assign busy = (state != IDLE);

  // Next state and grant decision; grants only happen from IDLE.
  always_comb begin
    state_nxt  = state;
    grant_addr = 1'b0;
    grant_data = 1'b0;
    case (state)
      IDLE: begin
        if (addr_req && (!data_req || rr_addr_first)) begin
          grant_addr = 1'b1;
          state_nxt  = SHIFT;
        end else if (data_req) begin
          grant_data = 1'b1;
          // Status bypass skips the conversion entirely.
          state_nxt  = output_enable ? SHIFT : DONE;
        end
      end
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      ch            <= CH_ADDR;
      rr_addr_first <= 1'b1;
      src           <= '0;
      cnt           <= '0;
      acc           <= '0;
      addr_digits   <= '0;
      data_digits   <= '0;
      addr_ack      <= 1'b0;
      data_ack      <= 1'b0;
      addr_valid    <= 1'b0;
      data_valid    <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr_ack   <= grant_addr;
      data_ack   <= grant_data;
      addr_valid <= 1'b0;
      data_valid <= 1'b0;

      // Pointer only moves when there was actually contention.
      if ((grant_addr || grant_data) && addr_req && data_req)
        rr_addr_first <= ~rr_addr_first;

      if (grant_addr) begin
        ch  <= CH_ADDR;
        // Left-align so the operand MSB is always src[SRC_W-1].
        src <= SRC_W'(addr_in) << (SRC_W - ADDR_W);
        cnt <= CNT_W'(ADDR_W);
        acc <= '0;
      end else if (grant_data) begin
        ch  <= CH_DATA;
        src <= SRC_W'(data_in) << (SRC_W - DATA_W);
        cnt <= CNT_W'(DATA_W);
        // Bypass preloads the status pattern; DONE then publishes it as-is.
        if (output_enable)
          acc <= '0;
        else
          acc <= {DIGITS{input_enable ? BCD_BLANK_IN : BCD_BLANK_OUT}};
      end

      if (state == SHIFT) begin
        // Top bit of the corrected accumulator falls off: result is mod 10^DIGITS.
        acc <= {acc_corr[ACC_W-2:0], src[SRC_W-1]};
        src <= src << 1;
        cnt <= cnt - CNT_W'(1);
      end

      if (state == DONE) begin
        if (ch == CH_ADDR) begin
          addr_digits <= acc;
          addr_valid  <= 1'b1;
        end else begin
          data_digits <= acc;
          data_valid  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scheduler.sv
module tb_bcd_display_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        addr_req;
  logic [11:0] addr_in;
  logic        data_req;
  logic [31:0] data_in;
  logic        output_enable;
  logic        input_enable;
  logic        addr_ack, data_ack, busy, addr_valid, data_valid;
  logic [15:0] addr_digits, data_digits;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  bcd_display_scheduler #(.ADDR_W(12), .DATA_W(32), .DIGITS(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .addr_req      (addr_req),
    .addr_in       (addr_in),
    .data_req      (data_req),
    .data_in       (data_in),
    .output_enable (output_enable),
    .input_enable  (input_enable),
    .addr_ack      (addr_ack),
    .data_ack      (data_ack),
    .busy          (busy),
    .addr_digits   (addr_digits),
    .data_digits   (data_digits),
    .addr_valid    (addr_valid),
    .data_valid    (data_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference: low four decimal digits packed as BCD.
  function automatic logic [15:0] bcd4(input longint unsigned v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic pick(input int sel);
    case (sel)
      0:       return addr_ack;
      1:       return data_ack;
      2:       return addr_valid;
      default: return data_valid;
    endcase
  endfunction

  // Counts negedges until the selected output is high (bounded).
  task automatic wait_ev(input int sel, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clock);
      n++;
      if (pick(sel)) break;
    end
  endtask

  // One single-channel transaction: request, check ack, drop request,
  // check latency and result.
  task automatic convert(input string tag, input bit is_data, input logic [31:0] value,
                         input bit oe, input bit ie, input logic [15:0] exp_digits,
                         input int exp_lat);
    int n;
    if (is_data) begin
      data_in = value; output_enable = oe; input_enable = ie; data_req = 1'b1;
    end else begin
      addr_in = value[11:0]; addr_req = 1'b1;
    end
    wait_ev(is_data ? 1 : 0, 10, n);
    chk({tag, "_ack"}, 32'(n), 32'd1);
    addr_req = 1'b0;
    data_req = 1'b0;
    wait_ev(is_data ? 3 : 2, 60, n);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_dig"}, 32'(is_data ? data_digits : addr_digits), 32'(exp_digits));
  endtask

  initial begin
    int n;
    int nack, nval;
    logic [3:0] order;
    logic [11:0] exp_a;
    logic [31:0] exp_d;
    int vcount;

    reset = 1'b1; addr_req = 1'b0; data_req = 1'b0;
    addr_in = '0; data_in = '0; output_enable = 1'b1; input_enable = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", 32'({addr_ack, data_ack, addr_valid, data_valid}), 32'd0);
    chk("rst_digits", {addr_digits, data_digits}, 32'd0);
    reset = 1'b0;

    convert("a4095", 1'b0, 32'd4095, 1'b1, 1'b0, 16'h4095, 13);
    chk("data_hold0", 32'(data_digits), 32'd0);
    convert("d1234", 1'b1, 32'd1234, 1'b1, 1'b0, 16'h1234, 33);
    convert("dallone", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 16'h7295, 33);
    convert("bypB", 1'b1, 32'd55, 1'b0, 1'b1, 16'hBBBB, 1);
    convert("bypA", 1'b1, 32'd55, 1'b0, 1'b0, 16'hAAAA, 1);
    convert("a0", 1'b0, 32'd0, 1'b1, 1'b0, 16'h0000, 13);
    chk("data_hold1", 32'(data_digits), 32'h0000AAAA);

    // Both requests raised together and held: expect A, D, A, D.
    addr_in = 12'd5; data_in = 32'd6; output_enable = 1'b1;
    addr_req = 1'b1; data_req = 1'b1;
    nack = 0; nval = 0; order = '0; exp_a = '0; exp_d = '0; n = 0;
    while (nval < 4 && n < 300) begin
      @(negedge clock);
      n++;
      if (addr_ack || data_ack) begin
        if (nack < 4) order[3 - nack] = data_ack;
        nack++;
        if (addr_ack) begin exp_a = addr_in; addr_in = addr_in + 12'd111; end
        else begin exp_d = data_in; data_in = data_in + 32'd2222; end
      end
      if (addr_valid) begin
        chk("rr_addr", 32'(addr_digits), 32'(bcd4(longint'(exp_a))));
        nval++;
      end
      if (data_valid) begin
        chk("rr_data", 32'(data_digits), 32'(bcd4(longint'(exp_d))));
        nval++;
      end
    end
    addr_req = 1'b0; data_req = 1'b0;
    chk("rr_nval", 32'(nval), 32'd4);
    chk("rr_order", 32'(order), 32'b0101);
    @(negedge clock);
    chk("rr_idle", 32'(busy), 32'd0);

    // Operand change during SHIFT must not affect the result.
    addr_in = 12'd12; addr_req = 1'b1;
    wait_ev(0, 10, n);
    chk("mid_ack", 32'(n), 32'd1);
    addr_req = 1'b0;
    repeat (3) @(negedge clock);
    addr_in = 12'd999;
    wait_ev(2, 60, n);
    chk("mid_lat", 32'(n), 32'd10);
    chk("mid_dig", 32'(addr_digits), 32'h0012);

    // Reset during a data conversion abandons it.
    data_in = 32'd1234; output_enable = 1'b1; data_req = 1'b1;
    wait_ev(1, 10, n);
    chk("rstmid_ack", 32'(n), 32'd1);
    data_req = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_dig", {addr_digits, data_digits}, 32'd0);
    reset = 1'b0;
    vcount = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_valid || addr_valid) vcount++;
    end
    chk("rstmid_novalid", 32'(vcount), 32'd0);
    chk("rstmid_dig2", 32'(data_digits), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
